// File: rtl/sdf_bitrev_reorder_if.sv
// Stream bundle for sdf_bitrev_reorder: bit-reversed input samples in, natural-order bins out.
// slave = reorder block side, master = producer/consumer side.
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif

interface sdf_bitrev_reorder_if #(
  parameter int unsigned DATA_WIDTH = `DATA_IN_WIDTH,
  parameter int unsigned LOG2N      = 6
);
  logic                  di_en;
  logic [DATA_WIDTH-1:0] di_re;
  logic [DATA_WIDTH-1:0] di_im;
  logic                  do_en;
  logic [DATA_WIDTH-1:0] do_re;
  logic [DATA_WIDTH-1:0] do_im;
  logic [LOG2N-1:0]      do_idx;

  modport master (
    output di_en, di_re, di_im,
    input  do_en, do_re, do_im, do_idx
  );

  modport slave (
    input  di_en, di_re, di_im,
    output do_en, do_re, do_im, do_idx
  );
endinterface

// File: rtl/sdf_bitrev_reorder.sv
// Ping-pong reorder buffer turning bit-reversed R2SDF output frames into natural bin order.
// Define SDF_REORDER_SOF_EN to add do_sof, high on the cycle carrying bin 0 of each frame.
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif

module sdf_bitrev_reorder #(
  parameter int unsigned DATA_WIDTH = `DATA_IN_WIDTH,
  parameter int unsigned LOG2N      = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sdf_bitrev_reorder_if.slave   bus
`ifdef SDF_REORDER_SOF_EN
  ,
  output logic                  do_sof
`endif
);

  localparam int unsigned N = 1 << LOG2N;

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e                  state_q, state_d;
  logic [LOG2N-1:0]        wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]        rd_cnt_q, rd_cnt_d;
  logic [LOG2N-1:0]        wr_addr;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic                    frame_done;
  logic [2*DATA_WIDTH-1:0] rd_word;

  logic                    do_en_q;
  logic [DATA_WIDTH-1:0]   do_re_q, do_im_q;
  logic [LOG2N-1:0]        do_idx_q;

  // Both banks live in one array, bank select is the address MSB.
  logic [2*DATA_WIDTH-1:0] mem [2*N];

  assign frame_done = bus.di_en && (&wr_cnt_q);

  always_comb begin
    wr_addr = '0;
    for (int i = 0; i < int'(LOG2N); i++) begin
      wr_addr[i] = wr_cnt_q[LOG2N-1-i];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.di_en) begin
      mem[{wr_bank_q, wr_addr}] <= {bus.di_re, bus.di_im};
    end
  end

  // Asynchronous read; the output register supplies the single stage of latency.
  assign rd_word = mem[{rd_bank_q, rd_cnt_q}];

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (bus.di_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (frame_done) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (frame_done) begin
      // A completing frame always (re)starts a read of the bank just filled.
      state_d   = StRead;
      rd_cnt_d  = '0;
      rd_bank_d = wr_bank_q;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRead: begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (&rd_cnt_q) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      do_en_q  <= 1'b0;
      do_re_q  <= '0;
      do_im_q  <= '0;
      do_idx_q <= '0;
    end else begin
      do_en_q <= (state_q == StRead);
      if (state_q == StRead) begin
        {do_re_q, do_im_q} <= rd_word;
        do_idx_q           <= rd_cnt_q;
      end
    end
  end

`ifdef SDF_REORDER_SOF_EN
  logic do_sof_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      do_sof_q <= 1'b0;
    end else begin
      do_sof_q <= (state_q == StRead) && (rd_cnt_q == '0);
    end
  end

  assign do_sof = do_sof_q;
`endif

  assign bus.do_en  = do_en_q;
  assign bus.do_re  = do_re_q;
  assign bus.do_im  = do_im_q;
  assign bus.do_idx = do_idx_q;

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Directed bench for sdf_bitrev_reorder at N=8, DATA_WIDTH=16; checks do_sof when
// SDF_REORDER_SOF_EN is defined.
module tb_sdf_bitrev_reorder;

  localparam int unsigned DW = 16;
  localparam int unsigned LN = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  sdf_bitrev_reorder_if #(.DATA_WIDTH(DW), .LOG2N(LN)) bus ();

`ifdef SDF_REORDER_SOF_EN
  logic do_sof;
`endif

  sdf_bitrev_reorder #(.DATA_WIDTH(DW), .LOG2N(LN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef SDF_REORDER_SOF_EN
    ,
    .do_sof  (do_sof)
`endif
  );

  always #5 clk = ~clk;

  // Observations happen at negedge t (after posedge t-1); input t is driven right after.
  // With the last frame sample driven at t=L, bin j is expected at t=L+2+j.

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.di_en = 1'b0;
    bus.di_re = '0;
    bus.di_im = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.do_en !== 1'b0 || bus.do_re !== '0 || bus.do_im !== '0 || bus.do_idx !== '0) begin
      errors++;
      $display("FAIL reset_hold en=%b re=%0d im=%0d idx=%0d want all 0",
               bus.do_en, bus.do_re, bus.do_im, bus.do_idx);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.do_en !== 1'b0 || bus.do_re !== '0 || bus.do_idx !== '0) begin
      errors++;
      $display("FAIL reset_release en=%b re=%0d idx=%0d want all 0",
               bus.do_en, bus.do_re, bus.do_idx);
    end
`ifdef SDF_REORDER_SOF_EN
    checks++;
    if (do_sof !== 1'b0) begin
      errors++;
      $display("FAIL reset_sof got %b want 0", do_sof);
    end
`endif
  endtask

  task automatic test_single_frame(input string tag);
    logic exp_en;
    for (int t = 0; t < 21; t++) begin
      exp_en = (t >= 9 && t < 17);
      checks++;
      if (bus.do_en !== exp_en) begin
        errors++;
        $display("FAIL %s_en t=%0d got %b want %b", tag, t, bus.do_en, exp_en);
      end
      if (exp_en) begin
        checks++;
        if (bus.do_re !== DW'(t - 9) || bus.do_im !== DW'(100) || bus.do_idx !== LN'(t - 9)) begin
          errors++;
          $display("FAIL %s_data t=%0d got re=%0d im=%0d idx=%0d want re=%0d im=100 idx=%0d",
                   tag, t, bus.do_re, bus.do_im, bus.do_idx, t - 9, t - 9);
        end
      end else if (t >= 17) begin
        checks++;
        if (bus.do_re !== DW'(7) || bus.do_idx !== LN'(7)) begin
          errors++;
          $display("FAIL %s_hold t=%0d got re=%0d idx=%0d want re=7 idx=7",
                   tag, t, bus.do_re, bus.do_idx);
        end
      end
      if (t < 8) begin
        bus.di_en = 1'b1;
        bus.di_re = DW'(br_tab[t]);
        bus.di_im = DW'(100);
      end else begin
        bus.di_en = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_en;
    logic exp_sof;
    int   sof_cnt = 0;
    for (int t = 0; t < 28; t++) begin
      exp_en  = (t >= 9 && t < 25);
      exp_sof = exp_en && (((t - 9) % 8) == 0);
      checks++;
      if (bus.do_en !== exp_en) begin
        errors++;
        $display("FAIL b2b_en t=%0d got %b want %b", t, bus.do_en, exp_en);
      end
      if (exp_en) begin
        checks++;
        if (bus.do_re !== DW'(t - 9) || bus.do_im !== DW'(100) || bus.do_idx !== LN'(t - 9)) begin
          errors++;
          $display("FAIL b2b_data t=%0d got re=%0d im=%0d idx=%0d want re=%0d im=100 idx=%0d",
                   t, bus.do_re, bus.do_im, bus.do_idx, t - 9, (t - 9) % 8);
        end
      end else if (t >= 25) begin
        checks++;
        if (bus.do_re !== DW'(15)) begin
          errors++;
          $display("FAIL b2b_hold t=%0d got re=%0d want 15", t, bus.do_re);
        end
      end
`ifdef SDF_REORDER_SOF_EN
      checks++;
      if (do_sof !== exp_sof) begin
        errors++;
        $display("FAIL b2b_sof t=%0d got %b want %b", t, do_sof, exp_sof);
      end
      if (do_sof === 1'b1) sof_cnt++;
`else
      if (exp_sof) sof_cnt++;
`endif
      if (t < 16) begin
        bus.di_en = 1'b1;
        bus.di_re = DW'((t < 8) ? br_tab[t] : 8 + br_tab[t - 8]);
        bus.di_im = DW'(100);
      end else begin
        bus.di_en = 1'b0;
      end
      @(negedge clk);
    end
`ifdef SDF_REORDER_SOF_EN
    checks++;
    if (sof_cnt != 2) begin
      errors++;
      $display("FAIL b2b_sof_count got %0d want 2", sof_cnt);
    end
`endif
  endtask

  task automatic test_gaps();
    logic exp_en;
    for (int t = 0; t < 28; t++) begin
      exp_en = (t >= 16 && t < 24);
      checks++;
      if (bus.do_en !== exp_en) begin
        errors++;
        $display("FAIL gaps_en t=%0d got %b want %b", t, bus.do_en, exp_en);
      end
      if (exp_en) begin
        checks++;
        if (bus.do_re !== DW'(t - 16) || bus.do_im !== DW'(100) || bus.do_idx !== LN'(t - 16)) begin
          errors++;
          $display("FAIL gaps_data t=%0d got re=%0d im=%0d idx=%0d want re=%0d im=100 idx=%0d",
                   t, bus.do_re, bus.do_im, bus.do_idx, t - 16, t - 16);
        end
      end
      if (t < 16 && (t % 2) == 0) begin
        bus.di_en = 1'b1;
        bus.di_re = DW'(br_tab[t / 2]);
        bus.di_im = DW'(100);
      end else begin
        bus.di_en = 1'b0;
        bus.di_re = DW'(999);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_partial_reset();
    for (int t = 0; t < 5; t++) begin
      bus.di_en = 1'b1;
      bus.di_re = DW'(50 + t);
      bus.di_im = DW'(77);
      @(negedge clk);
    end
    bus.di_en = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (bus.do_en !== 1'b0) begin
      errors++;
      $display("FAIL partial_reset_en got %b want 0", bus.do_en);
    end
    test_single_frame("partial");
  endtask

  task automatic test_reset_mid_burst();
    for (int t = 0; t < 12; t++) begin
      checks++;
      if (bus.do_en !== (t >= 9)) begin
        errors++;
        $display("FAIL mid_pre_en t=%0d got %b want %b", t, bus.do_en, (t >= 9));
      end
      if (t >= 9) begin
        checks++;
        if (bus.do_re !== DW'(t - 9)) begin
          errors++;
          $display("FAIL mid_pre_data t=%0d got re=%0d want %0d", t, bus.do_re, t - 9);
        end
      end
      bus.di_en = (t < 8);
      bus.di_re = DW'((t < 8) ? br_tab[t] : 0);
      bus.di_im = DW'(100);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.do_en !== 1'b0 || bus.do_re !== '0 || bus.do_idx !== '0) begin
      errors++;
      $display("FAIL mid_async en=%b re=%0d idx=%0d want all 0",
               bus.do_en, bus.do_re, bus.do_idx);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      checks++;
      if (bus.do_en !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet t=%0d got en=%b want 0", t, bus.do_en);
      end
    end
    test_single_frame("after_mid");
  endtask

  initial begin
    test_reset();
    test_single_frame("frame");
    test_back_to_back();
    test_gaps();
    test_partial_reset();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
